// File: rtl/fpoly_pow_axpy_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fpoly_pow_axpy_pipe (with helpers fpoly_delay, f_mult, f_add)
//  Purpose  : Fully pipelined IEEE-754 binary64 evaluator of
//             res = a**POW + COEF*b + c. It accepts one argument set per clock
//             and has no stalls. A sideband tag travels with each set. The
//             block also provides an in-flight count, a sticky arithmetic
//             error flag and a latency-alignment check.
//  Ports    : clk, rst (sync, active-high)
//             arg_vld, a, b, c, arg_tag   - argument set in
//             res_vld, res, res_tag       - result out, LAT cycles later
//             in_flight                   - accepted sets not yet delivered
//             err                         - sticky: an operator reported non-finite
//             align_err                   - sticky: res_vld disagreed with valid line
//  Revision : 1.0 - initial release
// ============================================================================

// Clearable shift register of depth D (D >= 1).
module fpoly_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] sr [D];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[D-1];
endmodule

// binary64 multiply, round-to-nearest-even. Subnormal inputs and results are
// flushed to zero. error flags any non-finite result.
module f_mult #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        down_valid,
    output logic [63:0] result,
    output logic        error
);
    logic               sa, sb, sr, za, zb, ia, ib, na, nb, g, st;
    logic [10:0]        ea, eb;
    logic [51:0]        fa, fb;
    logic [105:0]       prod;
    logic [52:0]        mr;
    logic signed [13:0] e;
    logic [63:0]        res_c;
    logic               err_c;
    logic [65:0]        pipe_out;

    if (LAT < 1) begin : g_lat_check
        $error("f_mult: LAT must be at least 1");
    end

    always_comb begin
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        za   = (ea == 11'd0);
        zb   = (eb == 11'd0);
        ia   = (ea == 11'h7FF) && (fa == 52'd0);
        ib   = (eb == 11'h7FF) && (fb == 52'd0);
        na   = (ea == 11'h7FF) && (fa != 52'd0);
        nb   = (eb == 11'h7FF) && (fb != 52'd0);
        sr   = sa ^ sb;
        prod = {53'd0, 1'b1, fa} * {53'd0, 1'b1, fb};
        e    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;
        // Product of two [1,2) significands lies in [1,4): at most one normalising shift.
        if (prod[105]) begin
            mr = {1'b0, prod[104:53]};
            g  = prod[52];
            st = |prod[51:0];
            e  = e + 14'sd1;
        end else begin
            mr = {1'b0, prod[103:52]};
            g  = prod[51];
            st = |prod[50:0];
        end
        mr = mr + {52'd0, g & (st | mr[0])};
        if (mr[52]) e = e + 14'sd1;   // rounding carried into a new binade
        res_c = {sr, e[10:0], mr[51:0]};
        err_c = 1'b0;
        if (e >= 14'sd2047) begin
            res_c = {sr, 11'h7FF, 52'd0};
            err_c = 1'b1;
        end else if (e <= 14'sd0) begin
            res_c = {sr, 63'd0};
        end
        if (na || nb || (ia && zb) || (ib && za)) begin
            res_c = 64'h7FF8000000000000;
            err_c = 1'b1;
        end else if (ia || ib) begin
            res_c = {sr, 11'h7FF, 52'd0};
            err_c = 1'b1;
        end else if (za || zb) begin
            res_c = {sr, 63'd0};
            err_c = 1'b0;
        end
    end

    fpoly_delay #(.W(66), .D(LAT)) u_pipe (
        .clk (clk), .rst (rst), .din ({up_valid, err_c, res_c}), .dout (pipe_out)
    );
    assign down_valid = pipe_out[65];
    assign error      = pipe_out[64];
    assign result     = pipe_out[63:0];
endmodule

// binary64 add, round-to-nearest-even, guard/round/sticky alignment.
// Subnormals flush to zero. error flags any non-finite result.
module f_add #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        down_valid,
    output logic [63:0] result,
    output logic        error
);
    logic               sa, sb, sx, sy, za, zb, ia, ib, na, nb, swap, g, st;
    logic [10:0]        ea, eb, ex, ey, d;
    logic [51:0]        fa, fb, fx, fy;
    logic [5:0]         dcap, lz;
    logic [55:0]        xal, yal, n;
    logic [119:0]       wide;
    logic [56:0]        sum;
    logic [52:0]        mr;
    logic signed [13:0] e;
    logic [63:0]        res_c;
    logic               err_c;
    logic [65:0]        pipe_out;

    if (LAT < 1) begin : g_lat_check
        $error("f_add: LAT must be at least 1");
    end

    always_comb begin
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        za   = (ea == 11'd0);
        zb   = (eb == 11'd0);
        ia   = (ea == 11'h7FF) && (fa == 52'd0);
        ib   = (eb == 11'h7FF) && (fb == 52'd0);
        na   = (ea == 11'h7FF) && (fa != 52'd0);
        nb   = (eb == 11'h7FF) && (fb != 52'd0);
        // x is the larger magnitude, so x - y never goes negative.
        swap = {ea, fa} < {eb, fb};
        {sx, ex, fx} = swap ? b : a;
        {sy, ey, fy} = swap ? a : b;
        d    = ex - ey;
        dcap = (d > 11'd63) ? 6'd63 : d[5:0];
        xal  = {1'b1, fx, 3'b000};
        wide = {1'b1, fy, 3'b000, 64'd0} >> dcap;
        yal  = {wide[119:65], |wide[64:0]};   // fold shifted-out bits into sticky
        sum  = (sx ^ sy) ? ({1'b0, xal} - {1'b0, yal}) : ({1'b0, xal} + {1'b0, yal});
        lz   = 6'd0;
        for (int i = 0; i < 56; i++) begin
            if (sum[i]) lz = 6'(55 - i);
        end
        e = $signed({3'b000, ex});
        if (sum[56]) begin
            n = {sum[56:2], sum[1] | sum[0]};
            e = e + 14'sd1;
        end else begin
            n = sum[55:0] << lz;
            e = e - $signed({8'd0, lz});
        end
        g  = n[2];
        st = n[1] | n[0];
        mr = {1'b0, n[54:3]};
        mr = mr + {52'd0, g & (st | mr[0])};
        if (mr[52]) e = e + 14'sd1;
        res_c = {sx, e[10:0], mr[51:0]};
        err_c = 1'b0;
        if (sum == 57'd0) begin
            res_c = 64'd0;
        end else if (e >= 14'sd2047) begin
            res_c = {sx, 11'h7FF, 52'd0};
            err_c = 1'b1;
        end else if (e <= 14'sd0) begin
            res_c = {sx, 63'd0};
        end
        if (na || nb || (ia && ib && (sa != sb))) begin
            res_c = 64'h7FF8000000000000;
            err_c = 1'b1;
        end else if (ia) begin
            res_c = a;
            err_c = 1'b1;
        end else if (ib) begin
            res_c = b;
            err_c = 1'b1;
        end else if (za && zb) begin
            res_c = {sa & sb, 63'd0};
            err_c = 1'b0;
        end else if (za) begin
            res_c = b;
            err_c = 1'b0;
        end else if (zb) begin
            res_c = a;
            err_c = 1'b0;
        end
    end

    fpoly_delay #(.W(66), .D(LAT)) u_pipe (
        .clk (clk), .rst (rst), .din ({up_valid, err_c, res_c}), .dout (pipe_out)
    );
    assign down_valid = pipe_out[65];
    assign error      = pipe_out[64];
    assign result     = pipe_out[63:0];
endmodule

module fpoly_pow_axpy_pipe #(
    parameter int          POW      = 5,
    parameter logic [63:0] COEF     = 64'h3FD3333333333333,
    parameter int          TAG_W    = 4,
    parameter int          MULT_LAT = 3,
    parameter int          ADD_LAT  = 2,
    localparam int         LAT      = (POW - 1) * MULT_LAT + 2 * ADD_LAT,
    localparam int         CNT_W    = $clog2(LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    input  logic [63:0]      a,
    input  logic [63:0]      b,
    input  logic [63:0]      c,
    input  logic [TAG_W-1:0] arg_tag,
    output logic             res_vld,
    output logic [63:0]      res,
    output logic [TAG_W-1:0] res_tag,
    output logic [CNT_W-1:0] in_flight,
    output logic             err,
    output logic             align_err
);
    if (POW < 2 || POW > 8) begin : g_pow_check
        $error("fpoly_pow_axpy_pipe: POW must be in 2..8");
    end

    logic [63:0]      p      [POW];       // p[k] = a**(k+1); p[0] is a itself
    logic             pv     [POW];
    logic [63:0]      a_dly  [1:POW-1];   // a aligned with power stage k
    logic [POW+1:0]   op_err;             // per-operator error, qualified by down_valid
    logic [63:0]      q, q_al, s, c_al;
    logic             q_vld, s_vld, q_err, s_err, r_err;
    logic             vld_m1, vld_line;
    logic [TAG_W-1:0] tag_m1;

    assign p[0]     = a;
    assign pv[0]    = arg_vld;
    assign a_dly[1] = a;

    for (genvar k = 1; k < POW; k++) begin : g_pow_stage
        logic m_err;
        if (k > 1) begin : g_a_dly
            fpoly_delay #(.W(64), .D(MULT_LAT)) u_a_dly (
                .clk (clk), .rst (rst), .din (a_dly[k-1]), .dout (a_dly[k])
            );
        end
        f_mult #(.LAT(MULT_LAT)) u_mul (
            .clk (clk), .rst (rst), .up_valid (pv[k-1]), .a (p[k-1]), .b (a_dly[k]),
            .down_valid (pv[k]), .result (p[k]), .error (m_err)
        );
        assign op_err[k-1] = m_err & pv[k];
    end

    // COEF*b finishes after one multiply; hold it until the power chain catches up.
    f_mult #(.LAT(MULT_LAT)) u_mul_q (
        .clk (clk), .rst (rst), .up_valid (arg_vld), .a (b), .b (COEF),
        .down_valid (q_vld), .result (q), .error (q_err)
    );
    if (POW > 2) begin : g_q_dly
        fpoly_delay #(.W(64), .D((POW - 2) * MULT_LAT)) u_q_dly (
            .clk (clk), .rst (rst), .din (q), .dout (q_al)
        );
    end else begin : g_q_direct
        assign q_al = q;
    end

    f_add #(.LAT(ADD_LAT)) u_add_s (
        .clk (clk), .rst (rst), .up_valid (pv[POW-1]), .a (p[POW-1]), .b (q_al),
        .down_valid (s_vld), .result (s), .error (s_err)
    );

    fpoly_delay #(.W(64), .D((POW - 1) * MULT_LAT + ADD_LAT)) u_c_dly (
        .clk (clk), .rst (rst), .din (c), .dout (c_al)
    );

    f_add #(.LAT(ADD_LAT)) u_add_r (
        .clk (clk), .rst (rst), .up_valid (s_vld), .a (s), .b (c_al),
        .down_valid (res_vld), .result (res), .error (r_err)
    );

    assign op_err[POW-1] = q_err & q_vld;
    assign op_err[POW]   = s_err & s_vld;
    assign op_err[POW+1] = r_err & res_vld;

    // Reference valid/tag lines stop one short of LAT; the final register
    // stage below lines them up with the last adder's output.
    fpoly_delay #(.W(1 + TAG_W), .D(LAT - 1)) u_vld_tag (
        .clk (clk), .rst (rst), .din ({arg_vld, arg_tag}), .dout ({vld_m1, tag_m1})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_line  <= 1'b0;
            res_tag   <= '0;
            in_flight <= '0;
            err       <= 1'b0;
            align_err <= 1'b0;
        end else begin
            vld_line <= vld_m1;
            if (vld_m1) res_tag <= tag_m1;
            if (res_vld != vld_line) align_err <= 1'b1;
            if (|op_err) err <= 1'b1;
            if (arg_vld && !res_vld) in_flight <= in_flight + CNT_W'(1);
            else if (!arg_vld && res_vld) in_flight <= in_flight - CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpoly_pow_axpy_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpoly_pow_axpy_pipe
//  Purpose  : Self-checking bench for fpoly_pow_axpy_pipe. The reference is
//             real arithmetic in the operation order a**POW, COEF*b, sum, +c.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpoly_pow_axpy_pipe;
    localparam int          MLAT = 3;
    localparam int          ALAT = 2;
    localparam int          LAT5 = 4 * MLAT + 2 * ALAT;
    localparam int          LAT2 = 1 * MLAT + 2 * ALAT;
    localparam int          LAT8 = 7 * MLAT + 2 * ALAT;
    localparam logic [63:0] COEF = 64'h3FD3333333333333;

    typedef struct {
        logic [63:0] r;
        logic [3:0]  t;
        int          cy;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arg_vld = 1'b0;
    logic [63:0] a = '0, b = '0, c = '0;
    logic [3:0]  arg_tag = '0;

    logic        res_vld, err, align_err;
    logic [63:0] res;
    logic [3:0]  res_tag;
    logic [4:0]  in_flight;
    logic        res_vld2, err2, align_err2;
    logic [63:0] res2;
    logic [0:0]  res_tag2;
    logic [2:0]  in_flight2;
    logic        res_vld8, err8, align_err8;
    logic [63:0] res8;
    logic [0:0]  res_tag8;
    logic [4:0]  in_flight8;

    int    cyc = 0;
    int    max_if = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    item_t exp_q[$];
    item_t obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpoly_pow_axpy_pipe #(.POW(5), .COEF(COEF), .TAG_W(4), .MULT_LAT(MLAT), .ADD_LAT(ALAT)) dut (
        .clk (clk), .rst (rst), .arg_vld (arg_vld), .a (a), .b (b), .c (c), .arg_tag (arg_tag),
        .res_vld (res_vld), .res (res), .res_tag (res_tag), .in_flight (in_flight),
        .err (err), .align_err (align_err)
    );
    fpoly_pow_axpy_pipe #(.POW(2), .COEF(COEF), .TAG_W(1), .MULT_LAT(MLAT), .ADD_LAT(ALAT)) dut_p2 (
        .clk (clk), .rst (rst), .arg_vld (arg_vld), .a (a), .b (b), .c (c), .arg_tag (arg_tag[0:0]),
        .res_vld (res_vld2), .res (res2), .res_tag (res_tag2), .in_flight (in_flight2),
        .err (err2), .align_err (align_err2)
    );
    fpoly_pow_axpy_pipe #(.POW(8), .COEF(COEF), .TAG_W(1), .MULT_LAT(MLAT), .ADD_LAT(ALAT)) dut_p8 (
        .clk (clk), .rst (rst), .arg_vld (arg_vld), .a (a), .b (b), .c (c), .arg_tag (arg_tag[0:0]),
        .res_vld (res_vld8), .res (res8), .res_tag (res_tag8), .in_flight (in_flight8),
        .err (err8), .align_err (align_err8)
    );

    // Collect every delivered result of the main instance with its cycle stamp.
    always @(negedge clk) begin
        if (res_vld) obs_q.push_back('{r: res, t: res_tag, cy: cyc});
        if (int'(in_flight) > max_if) max_if = int'(in_flight);
    end

    function automatic logic [63:0] model(input logic [63:0] av, bv, cv, input int pw);
        real ra, p, q, s;
        ra = $bitstoreal(av);
        p  = ra * ra;
        for (int k = 2; k < pw; k++) p = p * ra;
        q  = $bitstoreal(bv) * $bitstoreal(COEF);
        s  = p + q;
        s  = s + $bitstoreal(cv);
        return $realtobits(s);
    endfunction

    // Random normal operand with magnitude in roughly [2^-3, 2^4).
    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        logic [31:0] hi;
        hi       = $urandom;
        v[63]    = 1'($urandom_range(0, 1));
        v[62:52] = 11'(1020 + $urandom_range(0, 6));
        v[51:32] = hi[19:0];
        v[31:0]  = $urandom;
        return v;
    endfunction

    // One clock of stimulus; accepted sets (outside reset) go to the expected queue.
    task automatic drive(input logic v, input logic [63:0] av, bv, cv, input logic [3:0] tv);
        arg_vld = v; a = av; b = bv; c = cv; arg_tag = tv;
        if (v && !rst) exp_q.push_back('{r: model(av, bv, cv, 5), t: tv, cy: cyc + LAT5});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 64'd0, 64'd0, 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks += 6;
        if (res_vld !== 1'b0) $display("FAIL reset_res_vld got=%b want=0", res_vld); else n_pass++;
        if (in_flight !== 5'd0) $display("FAIL reset_in_flight got=%0d want=0", in_flight); else n_pass++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else n_pass++;
        if (align_err !== 1'b0) $display("FAIL reset_align_err got=%b want=0", align_err); else n_pass++;
        if (res !== 64'd0) $display("FAIL reset_res got=%h want=0", res); else n_pass++;
        if (res_tag !== 4'd0) $display("FAIL reset_res_tag got=%h want=0", res_tag); else n_pass++;
        rst = 1'b0;
        idle(1);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single();
        drive(1'b1, 64'h4000000000000000, 64'd0, 64'h3FF0000000000000, 4'd3);
        idle(LAT5 / 2);
        n_checks++;
        if (in_flight !== 5'd1) $display("FAIL single_in_flight_mid got=%0d want=1", in_flight); else n_pass++;
        idle(LAT5);
        n_checks++;
        if (obs_q.size() != 1) $display("FAIL single_count got=%0d want=1", obs_q.size());
        else begin
            n_pass++;
            n_checks += 3;
            if (obs_q[0].r !== 64'h4040800000000000) $display("FAIL single_res got=%h want=4040800000000000", obs_q[0].r); else n_pass++;
            if (obs_q[0].t !== 4'd3) $display("FAIL single_tag got=%0d want=3", obs_q[0].t); else n_pass++;
            if (obs_q[0].cy != exp_q[0].cy) $display("FAIL single_latency got_cycle=%0d want_cycle=%0d", obs_q[0].cy, exp_q[0].cy); else n_pass++;
        end
        n_checks++;
        if (in_flight !== 5'd0) $display("FAIL single_in_flight_end got=%0d want=0", in_flight); else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [3:0] tg = 4'd0;
        max_if = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, rnd_op(), rnd_op(), rnd_op(), tg);
            tg = tg + 4'd1;
        end
        idle(LAT5 + 2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].t !== exp_q[i].t || obs_q[i].cy != exp_q[i].cy)
                $display("FAIL b2b_item%0d got=%h/%0d@%0d want=%h/%0d@%0d", i, obs_q[i].r, obs_q[i].t,
                         obs_q[i].cy, exp_q[i].r, exp_q[i].t, exp_q[i].cy);
            else n_pass++;
        end
        n_checks += 3;
        if (align_err !== 1'b0) $display("FAIL b2b_align_err got=%b want=0", align_err); else n_pass++;
        if (max_if != LAT5) $display("FAIL b2b_in_flight_peak got=%0d want=%0d", max_if, LAT5); else n_pass++;
        if (in_flight !== 5'd0) $display("FAIL b2b_in_flight_end got=%0d want=0", in_flight); else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random_valid();
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), rnd_op(), rnd_op(), rnd_op(), 4'($urandom_range(0, 15)));
        idle(LAT5 + 2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL duty_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].t !== exp_q[i].t || obs_q[i].cy != exp_q[i].cy)
                $display("FAIL duty_item%0d got=%h/%0d@%0d want=%h/%0d@%0d", i, obs_q[i].r, obs_q[i].t,
                         obs_q[i].cy, exp_q[i].r, exp_q[i].t, exp_q[i].cy);
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, rnd_op(), rnd_op(), rnd_op(), 4'(i));
        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(1'b1, rnd_op(), rnd_op(), rnd_op(), 4'd9);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        n_checks += 3;
        if (in_flight !== 5'd0) $display("FAIL rstmid_in_flight got=%0d want=0", in_flight); else n_pass++;
        if (err !== 1'b0) $display("FAIL rstmid_err got=%b want=0", err); else n_pass++;
        if (align_err !== 1'b0) $display("FAIL rstmid_align_err got=%b want=0", align_err); else n_pass++;
        idle(LAT5 + 4);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL rstmid_stale got=%0d want=0", obs_q.size()); else n_pass++;
        drive(1'b1, rnd_op(), rnd_op(), rnd_op(), 4'd7);
        idle(LAT5 + 2);
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL rstmid_fresh_count got=%0d want=1", obs_q.size());
        else if (obs_q[0].r !== exp_q[0].r || obs_q[0].t !== 4'd7 || obs_q[0].cy != exp_q[0].cy)
            $display("FAIL rstmid_fresh got=%h/%0d@%0d want=%h/7@%0d", obs_q[0].r, obs_q[0].t, obs_q[0].cy,
                     exp_q[0].r, exp_q[0].cy);
        else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_overflow();
        drive(1'b1, $realtobits(1.0e200), 64'h3FF0000000000000, 64'h3FF0000000000000, 4'd5);
        idle(LAT5 + 2);
        n_checks++;
        if (err !== 1'b1) $display("FAIL ovf_err_set got=%b want=1", err); else n_pass++;
        drive(1'b1, rnd_op(), rnd_op(), rnd_op(), 4'd6);
        idle(LAT5 + 2);
        n_checks += 2;
        if (err !== 1'b1) $display("FAIL ovf_err_sticky got=%b want=1", err); else n_pass++;
        if (obs_q.size() != 2) $display("FAIL ovf_count got=%0d want=2", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].t !== exp_q[i].t)
                $display("FAIL ovf_item%0d got=%h/%0d want=%h/%0d", i, obs_q[i].r, obs_q[i].t, exp_q[i].r, exp_q[i].t);
            else n_pass++;
        end
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_checks++;
        if (err !== 1'b0) $display("FAIL ovf_err_cleared got=%b want=0", err); else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_pow_variants();
        logic [63:0] got2, got8;
        int          cy2, cy8, start;
        logic        seen2, seen8, tg2, tg8;
        seen2 = 1'b0; seen8 = 1'b0; got2 = '0; got8 = '0; cy2 = 0; cy8 = 0; tg2 = 1'b0; tg8 = 1'b0;
        start = cyc;
        drive(1'b1, 64'h4000000000000000, 64'h4024000000000000, 64'd0, 4'd7);
        for (int i = 0; i < LAT8 + 4; i++) begin
            if (res_vld2 && !seen2) begin seen2 = 1'b1; got2 = res2; cy2 = cyc; tg2 = res_tag2[0]; end
            if (res_vld8 && !seen8) begin seen8 = 1'b1; got8 = res8; cy8 = cyc; tg8 = res_tag8[0]; end
            idle(1);
        end
        n_checks += 8;
        if (!seen2) $display("FAIL pow2_timeout got=none want=result"); else n_pass++;
        if (got2 !== model(64'h4000000000000000, 64'h4024000000000000, 64'd0, 2))
            $display("FAIL pow2_res got=%h want=%h", got2, model(64'h4000000000000000, 64'h4024000000000000, 64'd0, 2));
        else n_pass++;
        if (cy2 != start + LAT2) $display("FAIL pow2_latency got=%0d want=%0d", cy2 - start, LAT2); else n_pass++;
        if (tg2 !== 1'b1 || align_err2 !== 1'b0) $display("FAIL pow2_tag_align got=%b/%b want=1/0", tg2, align_err2); else n_pass++;
        if (!seen8) $display("FAIL pow8_timeout got=none want=result"); else n_pass++;
        if (got8 !== model(64'h4000000000000000, 64'h4024000000000000, 64'd0, 8))
            $display("FAIL pow8_res got=%h want=%h", got8, model(64'h4000000000000000, 64'h4024000000000000, 64'd0, 8));
        else n_pass++;
        if (cy8 != start + LAT8) $display("FAIL pow8_latency got=%0d want=%0d", cy8 - start, LAT8); else n_pass++;
        if (tg8 !== 1'b1 || align_err8 !== 1'b0) $display("FAIL pow8_tag_align got=%b/%b want=1/0", tg8, align_err8); else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_valid();
        test_reset_mid();
        test_overflow();
        test_pow_variants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
